command_sequencer: RTL and testbench

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

---
 rtl/command_sequencer_pkg.sv | 40 ++++
 rtl/command_sequencer_if.sv | 28 ++
 rtl/cmdseq_timeout.sv | 28 ++
 rtl/command_sequencer.sv | 127 ++++++++++++
 tb/tb_command_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/command_sequencer_pkg.sv
// Shared encodings for the command sequencer: input commands, op codes, FSM states
// and the CLEAR detection rule.
package command_sequencer_pkg;

  typedef enum logic [1:0] {
    CmdNop   = 2'b00,
    CmdPixel = 2'b01,
    CmdLine  = 2'b10,
    CmdRect  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    OpClear = 2'd0,
    OpPixel = 2'd1,
    OpLine  = 2'd2,
    OpRect  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StIssue = 2'd2
  } state_e;

  // A PIXEL command whose whole payload is ones means CLEAR.
  function automatic logic is_clear(input logic [1:0] cmd, input logic payload_all_ones);
    return (cmd == CmdPixel) && payload_all_ones;
  endfunction

  // Non-NOP command encodings line up with their op codes.
  function automatic op_e cmd_to_op(input logic [1:0] cmd);
    return op_e'(cmd);
  endfunction

  // Parameter-word count at which the operation is complete.
  function automatic logic [1:0] last_pcnt(input op_e op);
    return (op == OpPixel) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/command_sequencer_if.sv
// Command input stream and decoded-operation handshake of the command sequencer.
interface command_sequencer_if #(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned PARAM_W = 5
);
  import command_sequencer_pkg::*;

  logic               in_en;
  logic [1:0]         in_cmd;
  logic [PARAM_W-1:0] in_param;
  logic               op_valid;
  logic               op_ready;
  op_e                op_code;
  logic [COORD_W-1:0] x1, y1, x2, y2, w, h;
  logic               busy;
  logic               err;

  modport slave (
    input  in_en, in_cmd, in_param, op_ready,
    output op_valid, op_code, x1, y1, x2, y2, w, h, busy, err
  );

  modport master (
    output in_en, in_cmd, in_param, op_ready,
    input  op_valid, op_code, x1, y1, x2, y2, w, h, busy, err
  );

endinterface

// File: rtl/cmdseq_timeout.sv
// Idle-cycle watchdog for parameter loading; used only when CMDSEQ_TIMEOUT_EN is defined.
module cmdseq_timeout #(
  parameter int unsigned TO_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic fire
);

  localparam logic [TO_W-1:0] Last = TO_W'((1 << TO_W) - 2);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + TO_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Fires on the idle cycle that brings the count to its all-ones value.
  assign fire = run && (cnt_q == Last);

endmodule

// File: rtl/command_sequencer.sv
// Decodes a command/parameter word stream into drawing operations with a valid/ready handshake.
// Optional load timeout enabled by defining CMDSEQ_TIMEOUT_EN.
module command_sequencer
  import command_sequencer_pkg::*;
#(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned PARAM_W = 5,
  parameter int unsigned TO_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  command_sequencer_if.slave bus
);

  if (PARAM_W < COORD_W || TO_W < 2) begin : g_bad_param
    $error("command_sequencer: PARAM_W must be >= COORD_W and TO_W >= 2");
  end

  state_e             state_q;
  logic [1:0]         pcnt_q;
  logic               op_valid_q;
  logic               err_q;
  op_e                op_code_q;
  logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q, w_q, h_q;

  logic               start_cmd;
  logic               clear_cmd;
  logic [COORD_W-1:0] coord;

  assign coord     = bus.in_param[COORD_W-1:0];
  assign start_cmd = bus.in_en && (bus.in_cmd != CmdNop) && (state_q != StIssue);
  assign clear_cmd = is_clear(bus.in_cmd, &bus.in_param);

`ifdef CMDSEQ_TIMEOUT_EN
  logic timeout;

  cmdseq_timeout #(
    .TO_W (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .run   ((state_q == StLoad) && !bus.in_en),
    .fire  (timeout)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pcnt_q     <= 2'd0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      op_code_q  <= OpClear;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle, StLoad: begin
          if (start_cmd) begin
            // A command word mid-load abandons the partial command and starts afresh.
            err_q <= (state_q == StLoad);
            if (clear_cmd) begin
              op_code_q  <= OpClear;
              x1_q       <= '1;
              y1_q       <= '1;
              pcnt_q     <= 2'd0;
              op_valid_q <= 1'b1;
              state_q    <= StIssue;
            end else begin
              op_code_q <= cmd_to_op(bus.in_cmd);
              x1_q      <= coord;
              pcnt_q    <= 2'd1;
              state_q   <= StLoad;
            end
          end else if (state_q == StLoad && bus.in_en) begin
            unique case (pcnt_q)
              2'd1:    y1_q <= coord;
              2'd2:    if (op_code_q == OpLine) x2_q <= coord; else w_q <= coord;
              default: if (op_code_q == OpLine) y2_q <= coord; else h_q <= coord;
            endcase
            if (pcnt_q == last_pcnt(op_code_q)) begin
              pcnt_q     <= 2'd0;
              op_valid_q <= 1'b1;
              state_q    <= StIssue;
            end else begin
              pcnt_q <= pcnt_q + 2'd1;
            end
`ifdef CMDSEQ_TIMEOUT_EN
          end else if (state_q == StLoad && timeout) begin
            pcnt_q  <= 2'd0;
            err_q   <= 1'b1;
            state_q <= StIdle;
`endif
          end
        end
        StIssue: begin
          err_q <= bus.in_en;
          if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_code  = op_code_q;
  assign bus.x1       = x1_q;
  assign bus.y1       = y1_q;
  assign bus.x2       = x2_q;
  assign bus.y2       = y2_q;
  assign bus.w        = w_q;
  assign bus.h        = h_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Self-checking bench for command_sequencer: directed scenarios plus random word streams
// compared against a command-level reference model.
module tb_command_sequencer;
  import command_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   dut_xfers;

  command_sequencer_if #(.COORD_W(3), .PARAM_W(5)) bus ();

  command_sequencer #(
    .COORD_W (3),
    .PARAM_W (5),
    .TO_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.op_valid && bus.op_ready) dut_xfers <= dut_xfers + 1;
  end

  // Reference model: 0 idle, 1 collecting parameters, 2 offering an op.
  int m_mode, m_code, m_need, m_got, m_err, m_tcnt, m_xfers;
  int m_f[6];  // x1, y1, x2, y2, w, h

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input int code, input int k);
    if (k == 0) return 1;
    if (code == 2) return (k == 1) ? 2 : 3;
    return (k == 1) ? 4 : 5;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_need = 0; m_got = 0; m_err = 0; m_tcnt = 0;
    foreach (m_f[i]) m_f[i] = 0;
  endtask

  task automatic model_start(input int cmd, input int param);
    if (cmd == 1 && param == 31) begin
      m_code = 0; m_f[0] = 7; m_f[1] = 7; m_mode = 2;
    end else begin
      m_code = cmd; m_f[0] = param % 8; m_need = (cmd == 1) ? 1 : 3; m_got = 0; m_mode = 1;
    end
  endtask

  task automatic model_step(input int en, input int cmd, input int param, input int rdy);
    m_err = 0;
    case (m_mode)
      0: if (en != 0 && cmd != 0) model_start(cmd, param);
      1: begin
        if (en != 0) begin
          m_tcnt = 0;
          if (cmd == 0) begin
            m_f[slot(m_code, m_got)] = param % 8;
            m_got++;
            if (m_got == m_need) m_mode = 2;
          end else begin
            m_err = 1;
            model_start(cmd, param);
          end
        end else begin
`ifdef CMDSEQ_TIMEOUT_EN
          m_tcnt++;
          if (m_tcnt == 15) begin
            m_mode = 0;
            m_err  = 1;
          end
`endif
        end
      end
      default: begin
        if (en != 0) m_err = 1;
        if (rdy != 0) begin
          m_mode = 0;
          m_xfers++;
        end
      end
    endcase
    if (m_mode != 1) m_tcnt = 0;
  endtask

  task automatic compare_all(input string tag);
    int exp_f, got_f;
    exp_f = (m_f[0] << 15) | (m_f[1] << 12) | (m_f[2] << 9) | (m_f[3] << 6) | (m_f[4] << 3) | m_f[5];
    got_f = int'({bus.x1, bus.y1, bus.x2, bus.y2, bus.w, bus.h});
    check_eq({tag, ".valid"}, int'(bus.op_valid), (m_mode == 2) ? 1 : 0);
    check_eq({tag, ".busy"}, int'(bus.busy), (m_mode != 0) ? 1 : 0);
    check_eq({tag, ".err"}, int'(bus.err), m_err);
    check_eq({tag, ".code"}, int'(bus.op_code), m_code);
    check_eq({tag, ".fields"}, got_f, exp_f);
  endtask

  // Called at a falling edge; drives one word, checks state after the next rising edge.
  task automatic cycle(input string tag, input int en, input int cmd, input int param,
                       input int rdy);
    bus.in_en    = (en != 0);
    bus.in_cmd   = 2'(cmd);
    bus.in_param = 5'(param);
    bus.op_ready = (rdy != 0);
    model_step(en, cmd, param, rdy);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    check_eq({tag, ".zero"}, int'({bus.op_valid, bus.busy, bus.err, bus.op_code, bus.x1, bus.y1,
                                   bus.x2, bus.y2, bus.w, bus.h}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    n_checks = 0; n_fail = 0; dut_xfers = 0; m_xfers = 0;
    model_reset();
    rst_n = 1'b0;
    bus.in_en = 1'b0; bus.in_cmd = 2'b00; bus.in_param = '0; bus.op_ready = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // CLEAR: one word, op next cycle, one transfer.
    base = dut_xfers;
    cycle("clr", 1, 1, 31, 1);
    check_eq("clr.op", int'({bus.op_valid, bus.op_code, bus.x1, bus.y1}), (1 << 8) | (7 << 3) | 7);
    cycle("clr_xfer", 0, 0, 0, 1);
    check_eq("clr.count", dut_xfers - base, 1);

    // LINE held by back-pressure, then a single transfer.
    cycle("line0", 1, 2, 2, 0);
    cycle("line1", 1, 0, 3, 0);
    cycle("line2", 1, 0, 6, 0);
    cycle("line3", 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("line_hold", 0, 0, 0, 0);
    check_eq("line.op", int'({bus.op_valid, bus.op_code, bus.x1, bus.y1, bus.x2, bus.y2}),
             (1 << 14) | (2 << 12) | (2 << 9) | (3 << 6) | (6 << 3) | 1);
    base = dut_xfers;
    cycle("line_xfer", 0, 0, 0, 1);
    cycle("line_idle", 0, 0, 0, 1);
    check_eq("line.count", dut_xfers - base, 1);

    // Interrupted RECT restarts as PIXEL.
    cycle("rect0", 1, 3, 1, 0);
    cycle("rect1", 1, 0, 9, 0);
    cycle("rect_abort", 1, 1, 4, 0);
    check_eq("abort.err_x1", int'({bus.err, bus.busy, bus.op_valid, bus.x1, bus.y1}),
             (1 << 8) | (1 << 7) | (4 << 3) | 1);
    cycle("pix_wait", 0, 0, 0, 0);
    cycle("pix_y", 1, 0, 2, 0);

    // Word during ISSUE is dropped with an error pulse.
    cycle("issue_word", 1, 1, 5, 0);
    check_eq("issue.err_x1", int'({bus.err, bus.op_valid, bus.x1}), (1 << 4) | (1 << 3) | 4);
    cycle("issue_xfer", 0, 0, 0, 1);
    cycle("issue_idle", 0, 0, 0, 0);

    // Idle gap while loading a LINE.
    cycle("to_cmd", 1, 2, 0, 0);
`ifdef CMDSEQ_TIMEOUT_EN
    for (int i = 0; i < 14; i++) cycle("to_wait", 0, 0, 0, 0);
    check_eq("to.busy_before", int'(bus.busy), 1);
    cycle("to_fire", 0, 0, 0, 0);
    check_eq("to.fired", int'({bus.err, bus.busy}), 2);
`else
    for (int i = 0; i < 20; i++) cycle("to_wait", 0, 0, 0, 0);
    check_eq("to.still_busy", int'({bus.err, bus.busy}), 1);
`endif
    cycle("rl0", 1, 2, 3, 0);
    cycle("rl1", 1, 0, 1, 0);
    async_reset("rst_mid");
    for (int i = 0; i < 3; i++) cycle("rst_nop", 1, 0, 5, 0);
    check_eq("rst.idle", int'(bus.busy), 0);

    // Random word stream.
    for (int n = 0; n < 3000; n++) begin
      int en, cmd, param, rdy;
      if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < 16; i++) cycle("rnd_gap", 0, 0, 0, 0);
      end
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
      en    = ($urandom_range(0, 9) < 6) ? 1 : 0;
      cmd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
      param = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 31));
      rdy   = ($urandom_range(0, 2) != 0) ? 1 : 0;
      cycle("rnd", en, cmd, param, rdy);
    end

    check_eq("xfers", dut_xfers, m_xfers);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
